ir_nec_tx: RTL and testbench

IR_NEC_TX -- requirements
Module: ir_nec_tx

---
 rtl/ir_nec_pkg.sv | 36 +++
 rtl/ir_nec_tx_carrier.sv | 43 ++++
 rtl/ir_nec_tx.sv | 202 ++++++++++++++++++++
 tb/tb_ir_nec_tx.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_nec_pkg.sv
// ---------------------------------------------------------------------------
// ir_nec_pkg -- shared definitions for the NEC infrared transmitter/receiver.
// Holds the transmitter state encoding and every NEC timing constant,
// expressed in CLOCK_50 (50 MHz) cycles. No logic lives here.
// ---------------------------------------------------------------------------
package ir_nec_pkg;

  // Width of the single per-state down-counter (GAP of 2,000,000 fits in 21 bits)
  localparam int unsigned TIMER_W = 21;

  // Envelope timing, CLOCK_50 cycles
  localparam int unsigned LEAD_MARK_CYC  = 450000;
  localparam int unsigned LEAD_SPACE_CYC = 225000;
  localparam int unsigned REP_SPACE_CYC  = 112500;
  localparam int unsigned BIT_MARK_CYC   = 28125;  // also the stop mark
  localparam int unsigned BIT0_SPACE_CYC = 28125;
  localparam int unsigned BIT1_SPACE_CYC = 84375;
  localparam int unsigned GAP_CYC        = 2000000;

  // 38 kHz carrier: 1316-cycle period, 50 % duty
  localparam int unsigned CARRIER_PERIOD_CYC = 1316;
  localparam int unsigned CARRIER_HALF_CYC   = 658;
  localparam int unsigned CARRIER_W          = 11;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LEAD_MARK  = 3'd1,
    LEAD_SPACE = 3'd2,
    REP_SPACE  = 3'd3,
    BIT_MARK   = 3'd4,
    BIT_SPACE  = 3'd5,
    STOP_MARK  = 3'd6,
    GAP        = 3'd7
  } nec_state_t;

endpackage

// File: rtl/ir_nec_tx_carrier.sv
// ---------------------------------------------------------------------------
// ir_carrier_gen -- free-running 50 % duty carrier with phase restart.
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   restart   in   force the carrier high with a fresh phase on the next cycle
//   carrier   out  registered carrier, HALF_CYC cycles high then HALF_CYC low
// ---------------------------------------------------------------------------
module ir_carrier_gen
  import ir_nec_pkg::*;
#(
  parameter int unsigned HALF_CYC = CARRIER_HALF_CYC
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic restart,
  output logic carrier
);

  logic [CARRIER_W-1:0] cnt_q;
  logic                 carrier_q;

  // Half-period counter; toggles the carrier each time it wraps
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      carrier_q <= 1'b0;
    end else if (restart) begin
      // restart lines up with the first cycle of a mark, so that cycle is high
      cnt_q     <= '0;
      carrier_q <= 1'b1;
    end else if (cnt_q == CARRIER_W'(HALF_CYC - 1)) begin
      cnt_q     <= '0;
      carrier_q <= ~carrier_q;
    end else begin
      cnt_q     <= cnt_q + 1'b1;
      carrier_q <= carrier_q;
    end
  end

  assign carrier = carrier_q;

endmodule

// File: rtl/ir_nec_tx.sv
// ---------------------------------------------------------------------------
// ir_nec_tx -- NEC infrared frame / repeat-code transmitter.
// Ports:
//   CLOCK_50     in   50 MHz clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   one-cycle request for a full frame (wins over rpt)
//   rpt          in   one-cycle request for a repeat code
//   custom_code  in   16-bit address, [7:0] sent first
//   key_code     in   8-bit command, followed on air by its complement
//   busy         out  high from the cycle after acceptance through done
//   done         out  one-cycle pulse in the last cycle of the gap
//   tx_env       out  registered envelope, 1 = mark
//   IRDA_TXD     out  tx_env gated with the 38 kHz carrier
// The P_* parameters default to the NEC timings; they exist so the
// durations can be shortened for quick simulation.
// ---------------------------------------------------------------------------
module ir_nec_tx
  import ir_nec_pkg::*;
#(
  parameter int unsigned P_LEAD_MARK    = LEAD_MARK_CYC,
  parameter int unsigned P_LEAD_SPACE   = LEAD_SPACE_CYC,
  parameter int unsigned P_REP_SPACE    = REP_SPACE_CYC,
  parameter int unsigned P_BIT_MARK     = BIT_MARK_CYC,
  parameter int unsigned P_BIT0_SPACE   = BIT0_SPACE_CYC,
  parameter int unsigned P_BIT1_SPACE   = BIT1_SPACE_CYC,
  parameter int unsigned P_GAP          = GAP_CYC,
  parameter int unsigned P_CARRIER_HALF = CARRIER_HALF_CYC
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rpt,
  input  logic [15:0] custom_code,
  input  logic [7:0]  key_code,
  output logic        busy,
  output logic        done,
  output logic        tx_env,
  output logic        IRDA_TXD
);

  // Timer load value: a state lasting n cycles is entered with n-1
  function automatic logic [TIMER_W-1:0] load_f(input int unsigned cyc);
    return TIMER_W'(cyc - 1);
  endfunction

  nec_state_t         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [31:0]        shreg_q, shreg_d;
  logic [4:0]         bitcnt_q, bitcnt_d;
  logic               rep_q, rep_d;
  logic               env_q, env_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               restart_s;
  logic               carrier_s;
  logic               timer_zero_s;

  assign timer_zero_s = (timer_q == '0);

  // Next-state, timer and datapath decode
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    rep_d    = rep_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Air order is LSB first: custom low, custom high, key, ~key
          shreg_d  = {~key_code, key_code, custom_code[15:8], custom_code[7:0]};
          bitcnt_d = 5'd0;
          rep_d    = 1'b0;
          state_d  = LEAD_MARK;
          timer_d  = load_f(P_LEAD_MARK);
        end else if (rpt) begin
          rep_d   = 1'b1;
          state_d = LEAD_MARK;
          timer_d = load_f(P_LEAD_MARK);
        end else begin
          state_d = IDLE;
        end
      end
      LEAD_MARK: begin
        if (!timer_zero_s) begin
          timer_d = timer_q - 1'b1;
        end else if (rep_q) begin
          state_d = REP_SPACE;
          timer_d = load_f(P_REP_SPACE);
        end else begin
          state_d = LEAD_SPACE;
          timer_d = load_f(P_LEAD_SPACE);
        end
      end
      LEAD_SPACE: begin
        if (!timer_zero_s) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d = BIT_MARK;
          timer_d = load_f(P_BIT_MARK);
        end
      end
      REP_SPACE: begin
        if (!timer_zero_s) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d = STOP_MARK;
          timer_d = load_f(P_BIT_MARK);
        end
      end
      BIT_MARK: begin
        if (!timer_zero_s) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d = BIT_SPACE;
          timer_d = shreg_q[0] ? load_f(P_BIT1_SPACE) : load_f(P_BIT0_SPACE);
        end
      end
      BIT_SPACE: begin
        if (!timer_zero_s) begin
          timer_d = timer_q - 1'b1;
        end else begin
          shreg_d  = {1'b0, shreg_q[31:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          // bitcnt_q == 31 means the 32nd bit just finished (counter wraps to 0)
          if (bitcnt_q == 5'd31) begin
            state_d = STOP_MARK;
          end else begin
            state_d = BIT_MARK;
          end
          timer_d = load_f(P_BIT_MARK);
        end
      end
      STOP_MARK: begin
        if (!timer_zero_s) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d = GAP;
          timer_d = load_f(P_GAP);
        end
      end
      GAP: begin
        if (!timer_zero_s) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d = IDLE;
          rep_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    env_d  = (state_d == LEAD_MARK) || (state_d == BIT_MARK) || (state_d == STOP_MARK);
    busy_d = (state_d != IDLE);
    done_d = (state_d == GAP) && (timer_d == '0);
    // Marks are never adjacent, so a mark next state that differs from the
    // current one is always the first cycle of a fresh mark
    restart_s = env_d && (state_d != state_q);
  end

  // FSM, datapath and registered outputs
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      rep_q    <= 1'b0;
      env_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      rep_q    <= rep_d;
      env_q    <= env_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  ir_carrier_gen #(
    .HALF_CYC (P_CARRIER_HALF)
  ) u_carrier (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .restart  (restart_s),
    .carrier  (carrier_s)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_env   = env_q;
  assign IRDA_TXD = env_q & carrier_s;

endmodule

// File: tb/tb_ir_nec_tx.sv
module tb_ir_nec_tx;

  // Shortened timings keep every frame to about a thousand cycles
  localparam int LM   = 64;
  localparam int LS   = 32;
  localparam int RS   = 16;
  localparam int BM   = 8;
  localparam int B0   = 8;
  localparam int B1   = 24;
  localparam int GP   = 80;
  localparam int CH   = 3;
  localparam int MAXC = 4000;

  logic        CLOCK_50 = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        rpt = 1'b0;
  logic [15:0] custom_code = 16'h0000;
  logic [7:0]  key_code = 8'h00;
  logic        busy, done, tx_env, IRDA_TXD;

  int n_tests = 0;
  int n_fail  = 0;
  int runs_q[$];
  int exp_q[$];
  int carr_err, busy_err;
  bit timed_out;

  ir_nec_tx #(
    .P_LEAD_MARK(LM), .P_LEAD_SPACE(LS), .P_REP_SPACE(RS), .P_BIT_MARK(BM),
    .P_BIT0_SPACE(B0), .P_BIT1_SPACE(B1), .P_GAP(GP), .P_CARRIER_HALF(CH)
  ) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .start(start), .rpt(rpt),
    .custom_code(custom_code), .key_code(key_code),
    .busy(busy), .done(done), .tx_env(tx_env), .IRDA_TXD(IRDA_TXD)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Expected envelope run lengths of a full frame (marks and spaces alternate)
  task automatic build_frame(input logic [15:0] cc, input logic [7:0] kc);
    logic [7:0] bytes [4];
    bytes[0] = cc[7:0];
    bytes[1] = cc[15:8];
    bytes[2] = kc;
    bytes[3] = ~kc;
    exp_q.delete();
    exp_q.push_back(LM);
    exp_q.push_back(LS);
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 8; j++) begin
        exp_q.push_back(BM);
        exp_q.push_back(bytes[b][j] ? B1 : B0);
      end
    end
    exp_q.push_back(BM);
    exp_q.push_back(GP);
  endtask

  task automatic kick(input logic s, input logic r, input logic [15:0] cc, input logic [7:0] kc);
    @(negedge CLOCK_50);
    start = s; rpt = r; custom_code = cc; key_code = kc;
    @(negedge CLOCK_50);
    start = 1'b0; rpt = 1'b0;
  endtask

  // Record envelope run lengths until done; optionally inject requests mid-frame
  task automatic capture(input int inj_at);
    int   cur_len;
    logic cur;
    int   cyc;
    bit   fin;
    logic exp_irda;
    runs_q.delete();
    carr_err = 0; busy_err = 0; timed_out = 1'b0;
    cur = tx_env; cur_len = 0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < MAXC) begin
      if (tx_env !== cur) begin
        runs_q.push_back(cur_len);
        cur = tx_env;
        cur_len = 0;
      end
      exp_irda = cur && (((cur_len / CH) % 2) == 0);
      if (IRDA_TXD !== exp_irda) carr_err++;
      if (busy !== 1'b1) busy_err++;
      cur_len++;
      if (cyc == inj_at) begin
        start = 1'b1; rpt = 1'b1; custom_code = ~custom_code; key_code = ~key_code;
      end else if (cyc == inj_at + 1) begin
        start = 1'b0; rpt = 1'b0;
      end
      if (done === 1'b1) begin
        fin = 1'b1;
        runs_q.push_back(cur_len);
      end else begin
        cyc++;
        @(negedge CLOCK_50);
      end
    end
    if (!fin) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || tx_env !== 1'b0 || IRDA_TXD !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b tx_env=%b IRDA_TXD=%b, required all 0", busy, done, tx_env, IRDA_TXD);
    end
    start = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    n_tests++;
    if (busy !== 1'b0 || tx_env !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: busy=%b tx_env=%b, required 0 0", busy, tx_env);
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || tx_env !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b tx_env=%b, required 0 0 0", busy, done, tx_env);
    end
  endtask

  task automatic test_full_frame();
    kick(1'b1, 1'b0, 16'h6B86, 8'h12);
    n_tests++;
    if (tx_env !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_latency: tx_env=%b busy=%b, required 1 1", tx_env, busy);
    end
    build_frame(16'h6B86, 8'h12);
    capture(-10);
    n_tests++;
    if (timed_out || runs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL full_runs: got %0d runs (timeout=%0b), required %0d", runs_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < runs_q.size(); i++) begin
      n_tests++;
      if (runs_q[i] != exp_q[i]) begin
        n_fail++;
        $display("FAIL full_run[%0d]: got %0d cycles, required %0d", i, runs_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (carr_err != 0 || busy_err != 0) begin
      n_fail++;
      $display("FAIL full_carrier_busy: carrier errors %0d busy errors %0d, required 0 0", carr_err, busy_err);
    end
    @(negedge CLOCK_50);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL full_end: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_repeat();
    kick(1'b0, 1'b1, 16'h1234, 8'h56);
    n_tests++;
    if (tx_env !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rep_latency: tx_env=%b busy=%b, required 1 1", tx_env, busy);
    end
    exp_q.delete();
    exp_q.push_back(LM); exp_q.push_back(RS); exp_q.push_back(BM); exp_q.push_back(GP);
    capture(-10);
    n_tests++;
    if (timed_out || runs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rep_runs: got %0d runs (timeout=%0b), required %0d", runs_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < runs_q.size(); i++) begin
      n_tests++;
      if (runs_q[i] != exp_q[i]) begin
        n_fail++;
        $display("FAIL rep_run[%0d]: got %0d cycles, required %0d", i, runs_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (carr_err != 0 || busy_err != 0) begin
      n_fail++;
      $display("FAIL rep_carrier_busy: carrier errors %0d busy errors %0d, required 0 0", carr_err, busy_err);
    end
  endtask

  task automatic test_collision();
    kick(1'b1, 1'b1, 16'hA55A, 8'hC3);
    build_frame(16'hA55A, 8'hC3);
    capture(-10);
    n_tests++;
    if (timed_out || runs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL coll_runs: got %0d runs (timeout=%0b), required %0d", runs_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < runs_q.size(); i++) begin
      n_tests++;
      if (runs_q[i] != exp_q[i]) begin
        n_fail++;
        $display("FAIL coll_run[%0d]: got %0d cycles, required %0d", i, runs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int t;
    build_frame(16'h00FF, 8'h5A);
    t = LM + LS;
    for (int i = 0; i < 10; i++) t += exp_q[2 + 2 * i] + exp_q[3 + 2 * i];
    kick(1'b1, 1'b0, 16'h00FF, 8'h5A);
    capture(t + 2);  // lands inside the mark of bit 10
    n_tests++;
    if (timed_out || runs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL busy_runs: got %0d runs (timeout=%0b), required %0d", runs_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < runs_q.size(); i++) begin
      n_tests++;
      if (runs_q[i] != exp_q[i]) begin
        n_fail++;
        $display("FAIL busy_run[%0d]: got %0d cycles, required %0d", i, runs_q[i], exp_q[i]);
      end
    end
    repeat (5) @(negedge CLOCK_50);
    n_tests++;
    if (busy !== 1'b0 || tx_env !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_no_restart: busy=%b tx_env=%b, required 0 0", busy, tx_env);
    end
  endtask

  task automatic test_reset_in_mark();
    kick(1'b1, 1'b0, 16'hFFFF, 8'hFF);
    repeat (7) @(negedge CLOCK_50);
    n_tests++;
    if (tx_env !== 1'b1 || IRDA_TXD !== 1'b1) begin
      n_fail++;
      $display("FAIL mark_pre: tx_env=%b IRDA_TXD=%b, required 1 1", tx_env, IRDA_TXD);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (tx_env !== 1'b0 || IRDA_TXD !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mark_async_reset: tx_env=%b IRDA_TXD=%b busy=%b, required 0 0 0", tx_env, IRDA_TXD, busy);
    end
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);
  endtask

  task automatic test_mid_frame_reset();
    bit saw_done;
    kick(1'b1, 1'b0, 16'h6B86, 8'h12);
    repeat (LM + 4) @(negedge CLOCK_50);
    n_tests++;
    if (tx_env !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: tx_env=%b busy=%b, required 0 1", tx_env, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || tx_env !== 1'b0 || IRDA_TXD !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async_reset: busy=%b done=%b tx_env=%b IRDA_TXD=%b, required all 0", busy, done, tx_env, IRDA_TXD);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge CLOCK_50);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL mid_no_done: done seen during reset, required none");
    end
    // release and request in the same cycle: first edge must accept it
    rst_n = 1'b1; start = 1'b1; custom_code = 16'h6B86; key_code = 8'h00;
    @(negedge CLOCK_50);
    start = 1'b0;
    n_tests++;
    if (tx_env !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_restart_latency: tx_env=%b busy=%b, required 1 1", tx_env, busy);
    end
    build_frame(16'h6B86, 8'h00);
    capture(-10);
    n_tests++;
    if (timed_out || runs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL mid_runs: got %0d runs (timeout=%0b), required %0d", runs_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < runs_q.size(); i++) begin
      n_tests++;
      if (runs_q[i] != exp_q[i]) begin
        n_fail++;
        $display("FAIL mid_run[%0d]: got %0d cycles, required %0d", i, runs_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (carr_err != 0 || busy_err != 0) begin
      n_fail++;
      $display("FAIL mid_carrier_busy: carrier errors %0d busy errors %0d, required 0 0", carr_err, busy_err);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_repeat();
    test_collision();
    test_ignore_busy();
    test_reset_in_mark();
    test_mid_frame_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
